// File: rtl/trace_cmd_ctrl.sv
// trace_cmd_ctrl: parses A5/opcode/argument host commands and shares the UART transmitter between trace bytes and 2-byte replies.
// Optional macro CMD_TIMEOUT_EN: abandon a partial frame after TIMEOUT_CYCLES idle cycles.
module trace_cmd_ctrl #(
   parameter int TIMEOUT_CYCLES = 480000,
   parameter int MAX_BUS_WIDTH  = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_rx_valid,
   input  logic [7:0] i_rx_byte,
   input  logic       i_rx_err,
   input  logic       i_data_avail,
   input  logic [7:0] i_data_val,
   output logic       o_data_req,
   output logic       o_tx_transmit,
   output logic [7:0] o_tx_byte,
   input  logic       i_tx_done,
   input  logic       i_sync,
   input  logic       i_ovf,
   output logic [2:0] o_width,
   output logic       o_trace_en
);
   typedef enum logic [1:0] {P_HDR, P_OP, P_ARG, P_EXEC} pstate_t;
   typedef enum logic [1:0] {T_IDLE, T_TRACE, T_REPLY0, T_REPLY1} tstate_t;
   pstate_t    r_pst;
   tstate_t    r_tst;
   logic [7:0] r_op, r_arg, r_status;
   logic       r_rpend;
   logic       w_wok, w_ack, w_en_n, w_busy, w_exec, w_tmo;
   logic [2:0] w_width_n;
`ifdef CMD_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] r_cnt;
   // count idle cycles while a frame is partially received; any byte restarts the count
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_cnt <= '0;
      else if (i_rx_valid || !(r_pst == P_OP || r_pst == P_ARG)) r_cnt <= '0;
      else if (!w_tmo) r_cnt <= r_cnt + CW'(1);
   assign w_tmo = r_cnt == CW'(TIMEOUT_CYCLES);
`else
   assign w_tmo = TIMEOUT_CYCLES < 0;
`endif
   // decode the buffered command; status reflects the post-update width and enable
   always_comb begin
      w_wok     = (r_arg == 8'd1 || r_arg == 8'd2 || r_arg == 8'd4) && r_arg <= 8'(MAX_BUS_WIDTH);
      w_ack     = (r_op == 8'h01) ? w_wok : (r_op == 8'h02 || r_op == 8'h03);
      w_width_n = (r_op == 8'h01 && w_wok) ? r_arg[2:0] : o_width;
      w_en_n    = (r_op == 8'h02) ? r_arg[0] : o_trace_en;
      w_busy    = r_rpend || r_tst == T_REPLY0 || r_tst == T_REPLY1;
      w_exec    = r_pst == P_EXEC && !w_busy;
   end
   // command parser; a frame finishing while a reply is outstanding is dropped
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_pst      <= P_HDR;
         r_op       <= '0;
         r_arg      <= '0;
         r_status   <= '0;
         o_width    <= 3'(MAX_BUS_WIDTH);
         o_trace_en <= 1'b0;
      end else begin
         case (r_pst)
            P_HDR:  if (i_rx_valid && i_rx_byte == 8'hA5) r_pst <= P_OP;
            P_OP:   if (i_rx_err || (!i_rx_valid && w_tmo)) r_pst <= P_HDR;
                    else if (i_rx_valid) begin
                       r_op  <= i_rx_byte;
                       r_pst <= P_ARG;
                    end
            P_ARG:  if (i_rx_err || (!i_rx_valid && w_tmo)) r_pst <= P_HDR;
                    else if (i_rx_valid) begin
                       r_arg <= i_rx_byte;
                       r_pst <= P_EXEC;
                    end
            P_EXEC: r_pst <= P_HDR;
         endcase
         if (w_exec) begin
            o_width    <= w_width_n;
            o_trace_en <= w_en_n;
            r_status   <= {w_ack, i_sync, i_ovf, w_en_n, 1'b0, w_width_n};
         end
      end
   // transmit arbiter; decides only in T_IDLE, a pending reply beats trace data
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_tst         <= T_IDLE;
         r_rpend       <= 1'b0;
         o_tx_transmit <= 1'b0;
         o_tx_byte     <= '0;
         o_data_req    <= 1'b0;
      end else begin
         o_data_req <= 1'b0;
         if (w_exec) r_rpend <= 1'b1;
         case (r_tst)
            T_IDLE:   if (r_rpend) begin
                         r_rpend       <= 1'b0;
                         o_tx_byte     <= 8'h5A;
                         o_tx_transmit <= 1'b1;
                         r_tst         <= T_REPLY0;
                      end else if (o_trace_en && i_data_avail) begin
                         o_tx_byte     <= i_data_val;
                         o_tx_transmit <= 1'b1;
                         r_tst         <= T_TRACE;
                      end
            T_TRACE:  if (i_tx_done) begin
                         o_tx_transmit <= 1'b0;
                         o_data_req    <= 1'b1;
                         r_tst         <= T_IDLE;
                      end
            T_REPLY0: if (i_tx_done) begin
                         o_tx_byte <= r_status;
                         r_tst     <= T_REPLY1;
                      end
            T_REPLY1: if (i_tx_done) begin
                         o_tx_transmit <= 1'b0;
                         r_tst         <= T_IDLE;
                      end
         endcase
      end
endmodule

// File: tb/tb_trace_cmd_ctrl.sv
// tb_trace_cmd_ctrl: self-checking bench for trace_cmd_ctrl with a frame-level model and a UART/packFilter stand-in
module tb_trace_cmd_ctrl;
   localparam int TMO   = 60;
   localparam int TXLEN = 20;
   logic clk = 1'b0, rst_n = 1'b0;
   logic rx_valid = 1'b0, rx_err = 1'b0, tx_done = 1'b0, sync = 1'b0, ovf = 1'b0;
   logic data_avail = 1'b0;
   logic [7:0] rx_byte = '0, data_val = '0;
   logic data_req, tx_transmit, trace_en;
   logic [7:0] tx_byte;
   logic [2:0] width;
   int checks = 0, errors = 0, dreq_cnt = 0, txc = 0, m_after = 0, m_n = 0, m_idle = 0;
   logic [7:0] tx_log[$];
   logic [7:0] feed_q[$];
   logic [2:0] m_width;
   logic m_en, m_busy, m_busy_clr, m_exec, m_expect_status, m_dreq_exp, ok, ack;
   logic [7:0] m_status, m_op, m_arg;

   trace_cmd_ctrl #(.TIMEOUT_CYCLES(TMO), .MAX_BUS_WIDTH(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx_valid(rx_valid), .i_rx_byte(rx_byte), .i_rx_err(rx_err),
      .i_data_avail(data_avail), .i_data_val(data_val), .o_data_req(data_req),
      .o_tx_transmit(tx_transmit), .o_tx_byte(tx_byte), .i_tx_done(tx_done),
      .i_sync(sync), .i_ovf(ovf), .o_width(width), .o_trace_en(trace_en));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_width = 3'd4; m_en = 0; m_busy = 0; m_busy_clr = 0; m_exec = 0; m_expect_status = 0;
      m_dreq_exp = 0; m_status = 0; m_n = 0; m_idle = 0; m_after = 0; txc = 0; tx_done = 0;
   endtask

   // frame-level model: a complete frame takes effect one cycle later unless a reply is still owed
   always @(posedge clk) if (rst_n) begin
      if (m_exec) begin
         m_exec = 0;
         if (!m_busy) begin
            ok = (m_arg == 1 || m_arg == 2 || m_arg == 4) && m_arg <= 4;
            ack = 0;
            if (m_op == 8'h01) begin ack = ok; if (ok) m_width = m_arg[2:0]; end
            else if (m_op == 8'h02) begin ack = 1; m_en = m_arg[0]; end
            else if (m_op == 8'h03) ack = 1;
            m_status = {ack, sync, ovf, m_en, 1'b0, m_width};
            m_busy = 1;
         end
      end else if (m_n > 0 && rx_err) m_n = 0;
      else if (rx_valid) begin
         m_idle = 0;
         if (m_n == 0) m_n = (rx_byte == 8'hA5) ? 1 : 0;
         else if (m_n == 1) begin m_op = rx_byte; m_n = 2; end
         else begin m_arg = rx_byte; m_n = 0; m_exec = 1; end
      end else if (m_n > 0) begin
         m_idle++;
`ifdef CMD_TIMEOUT_EN
         if (m_idle > TMO) m_n = 0;
`endif
      end
      if (m_busy_clr) begin m_busy = 0; m_busy_clr = 0; end
   end

   // UART stand-in plus per-cycle comparison of DUT outputs against the model
   always @(negedge clk) begin
      if (!rst_n) begin
         tx_done = 0; txc = 0; m_after = 0; m_dreq_exp = 0;
      end else begin
         chk("width", width, m_width);
         chk("trace_en", trace_en, m_en);
         chk("data_req", data_req, m_dreq_exp);
         if (m_after != 0) chk("tx_after_byte", tx_transmit, m_after == 2);
         m_dreq_exp = 0; m_after = 0;
         if (tx_done) begin tx_done = 0; txc = 0; end
         else if (tx_transmit) begin
            txc++;
            if (txc == TXLEN) begin
               tx_done = 1;
               tx_log.push_back(tx_byte);
               if (m_expect_status) begin
                  chk("status_byte", tx_byte, m_status);
                  m_expect_status = 0; m_busy_clr = 1; m_after = 1;
               end else if (m_busy && tx_byte == 8'h5A) begin
                  m_expect_status = 1; m_after = 2;
               end else begin
                  m_dreq_exp = 1; m_after = 1;
               end
            end
         end else txc = 0;
      end
   end

   // packFilter stand-in: presents the queue head and pops it on data_req
   always @(negedge clk) begin
      if (data_req) begin
         dreq_cnt++;
         if (feed_q.size() > 0) feed_q.delete(0);
      end
      data_avail = feed_q.size() > 0;
      if (data_avail) data_val = feed_q[0]; else data_val = 8'h00;
   end

   task automatic send(input logic [7:0] b);
      rx_byte = b; rx_valid = 1; @(negedge clk); rx_valid = 0;
   endtask

   task automatic cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      send(a); @(negedge clk); send(b); @(negedge clk); send(c);
   endtask

   task automatic wait_log(input int n, input int budget);
      int k = 0;
      while (tx_log.size() < n && k < budget) begin @(negedge clk); k++; end
      chk("log_len", tx_log.size(), n);
      repeat (4) @(negedge clk);
   endtask

   task automatic chk_log(input int i, input logic [7:0] exp);
      chk($sformatf("tx_log[%0d]", i), (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hFFFF_FFFF, exp);
   endtask

   task automatic wait_tx(input logic [7:0] b);
      int k = 0;
      while (!(tx_transmit && tx_byte == b) && k < 500) begin @(negedge clk); k++; end
      chk($sformatf("wait_tx_%0h", b), tx_transmit && tx_byte == b, 1);
   endtask

   initial begin
      int hi;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_width", width, 3'd4);
      chk("rst_trace_en", trace_en, 0);
      chk("rst_tx_transmit", tx_transmit, 0);
      chk("rst_tx_byte", tx_byte, 8'h00);
      chk("rst_data_req", data_req, 0);
      rst_n = 1;
      @(negedge clk);
      // illegal width argument: NAK, width unchanged
      cmd(8'hA5, 8'h01, 8'h03);
      wait_log(2, 200);
      chk_log(0, 8'h5A); chk_log(1, 8'h04);
      chk("nak_width", width, 3'd4);
      tx_log.delete();
      // legal width: update lands at the end of the cycle after the argument
      send(8'hA5); @(negedge clk); send(8'h01); @(negedge clk); send(8'h02);
      chk("width_exec_cycle", width, 3'd4);
      @(negedge clk);
      chk("width_updated", width, 3'd2);
      wait_log(2, 200);
      chk_log(0, 8'h5A); chk_log(1, 8'h82);
      tx_log.delete();
      // enable tracing
      cmd(8'hA5, 8'h02, 8'h01);
      wait_log(2, 200);
      chk_log(0, 8'h5A); chk_log(1, 8'h92);
      tx_log.delete();
      // status command during trace byte 11, then a second command discarded while the reply is in flight
      dreq_cnt = 0;
      feed_q.push_back(8'h11); feed_q.push_back(8'h22);
      wait_tx(8'h11);
      sync = 1;
      cmd(8'hA5, 8'h03, 8'h00);
      @(negedge clk);
      sync = 0;
      wait_tx(8'h5A);
      cmd(8'hA5, 8'h01, 8'h01);
      wait_log(4, 400);
      chk_log(0, 8'h11); chk_log(1, 8'h5A); chk_log(2, 8'hD2); chk_log(3, 8'h22);
      chk("dreq_count", dreq_cnt, 2);
      chk("discard_width", width, 3'd2);
      tx_log.delete();
      // disable tracing; pending data must not be sent
      cmd(8'hA5, 8'h02, 8'h00);
      wait_log(2, 200);
      chk_log(0, 8'h5A); chk_log(1, 8'h82);
      tx_log.delete();
      dreq_cnt = 0; hi = 0;
      feed_q.push_back(8'h33);
      repeat (1000) begin @(negedge clk); if (tx_transmit) hi++; end
      chk("disabled_tx_cycles", hi, 0);
      chk("disabled_dreq", dreq_cnt, 0);
      feed_q.delete();
      // rx_err abandons a partial frame
      send(8'hA5); @(negedge clk); send(8'h01); @(negedge clk);
      rx_err = 1; @(negedge clk); rx_err = 0; @(negedge clk);
      send(8'h04);
      repeat (200) @(negedge clk);
      chk("err_no_reply", tx_log.size(), 0);
      chk("err_width", width, 3'd2);
      // long idle gap inside a frame
      send(8'hA5); @(negedge clk); send(8'h01);
      repeat (TMO + 5) @(negedge clk);
      send(8'h01);
`ifdef CMD_TIMEOUT_EN
      repeat (200) @(negedge clk);
      chk("tmo_no_reply", tx_log.size(), 0);
      chk("tmo_width", width, 3'd2);
`else
      wait_log(2, 200);
      chk_log(0, 8'h5A); chk_log(1, 8'h81);
      chk("notmo_width", width, 3'd1);
`endif
      tx_log.delete();
      // asynchronous reset while a reply byte is on the wire
      cmd(8'hA5, 8'h03, 8'h00);
      wait_tx(8'h5A);
      @(posedge clk); #2;
      rst_n = 0;
      #1;
      chk("arst_tx_transmit", tx_transmit, 0);
      chk("arst_tx_byte", tx_byte, 8'h00);
      chk("arst_width", width, 3'd4);
      chk("arst_trace_en", trace_en, 0);
      chk("arst_data_req", data_req, 0);
      model_reset();
      tx_log.delete();
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      ovf = 1;
      cmd(8'hA5, 8'h01, 8'h01);
      @(negedge clk);
      ovf = 0;
      wait_log(2, 200);
      chk_log(0, 8'h5A); chk_log(1, 8'hA1);
      chk("post_rst_width", width, 3'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/trace_cmd_ctrl.md
# trace_cmd_ctrl

Host-command controller and UART transmit arbiter for the trace pipeline. Parses 3-byte configuration commands arriving on the UART receiver. Drives the trace width and enable for the capture/packetising chain. Shares the single UART transmitter between the packFilter decoded-data stream and command replies.

## Interface
Parameters:
- TIMEOUT_CYCLES, 480000: idle cycles after which a partially received command is abandoned (10 ms at 48 MHz).
- MAX_BUS_WIDTH, 4: maximum legal trace width; also the reset value of `width`.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rx_valid  in  1  one-cycle strobe: `rx_byte` valid (UART `received`).
- rx_byte  in  8  received byte.
- rx_err  in  1  one-cycle strobe: UART receive error.
- data_avail  in  1  packFilter has a byte (DataAvail).
- data_val  in  8  packFilter byte (DataVal).
- data_req  out  1  one-cycle strobe: packFilter byte consumed (DataReq).
- tx_transmit  out  1  UART transmit request, level.
- tx_byte  out  8  byte to transmit.
- tx_done  in  1  one-cycle strobe: UART finished current byte.
- sync  in  1  packetiser sync indicator.
- ovf  in  1  filter overflow indicator.
- width  out  3  trace bus width: 1, 2 or 4.
- trace_en  out  1  trace data forwarding enable.

## Operation
- Command frame: header 0xA5, opcode, argument.
- Parser states:
  - P_HDR: non-0xA5 bytes are ignored.
  - P_OP: next byte is the opcode.
  - P_ARG: next byte is the argument.
  - P_EXEC: one cycle, then return to P_HDR.
- Opcodes:
  - 0x01 set width: argument 1, 2 or 4 (≤ MAX_BUS_WIDTH) updates `width` and ACKs. Any other argument NAKs with `width` unchanged.
  - 0x02 enable: argument bit0 → `trace_en`, ACK.
  - 0x03 status: argument ignored, ACK.
  - Any other opcode: NAK, no state change.
- Reply is 2 bytes: 0x5A, then the status byte {ack, sync, ovf, trace_en, 1'b0, width[2:0]}. Status bits are sampled in the P_EXEC cycle, after that cycle's update.
- Transmit arbiter states: T_IDLE, T_TRACE, T_REPLY0, T_REPLY1.
- From T_IDLE:
  - A pending reply wins: go to T_REPLY0.
  - Otherwise, if `trace_en` and `data_avail`: latch `data_val` and go to T_TRACE.
- Arbitration happens only at byte boundaries. A byte in flight is never aborted.
- Once T_REPLY0 starts, both reply bytes go out back-to-back; no trace byte is interleaved.
- `data_req` pulses only for trace bytes, never for reply bytes.
- Clearing `trace_en` mid-byte finishes that trace byte (including its `data_req`). No further trace bytes are started.
- Only one reply can be pending. A command completing while a reply is pending or in flight is discarded: no execution, no reply.
- `rx_err` in P_OP/P_ARG: abandon the frame and go to P_HDR.
- `rx_err` in P_HDR or P_EXEC is ignored.
- Reset values: `width`=MAX_BUS_WIDTH, `trace_en`=0, `tx_transmit`=0, `tx_byte`=0, `data_req`=0, parser P_HDR, arbiter T_IDLE, no reply pending.
- Reset mid-byte drops the byte; `tx_transmit` falls asynchronously.

## Timing
- P_EXEC occurs the cycle after the argument's `rx_valid`. `width`/`trace_en` update and the reply-pending flag set at the end of that cycle.
- T_IDLE → T_TRACE/T_REPLY0 takes 1 cycle. `tx_transmit` is high and `tx_byte` is stable the cycle after the decision. Both are held until `tx_done`.
- On `tx_done` for a trace byte, `data_req` pulses for exactly one cycle.
- On `tx_done` in T_TRACE or T_REPLY1, return to T_IDLE. The next decision is made in that T_IDLE cycle, so there is a minimum 1-cycle `tx_transmit` low gap between bytes.
- On `tx_done` in T_REPLY0, go directly to T_REPLY1. `tx_transmit` stays high and `tx_byte` changes the next cycle.
- Command to reply start: ≤1 trace byte of delay.
- `rx_valid` and `tx_done` in the same cycle are handled independently.

## Configuration
- CMD_TIMEOUT_EN defined:
  - A counter clears on each `rx_valid` and counts while the parser is in P_OP/P_ARG.
  - On reaching TIMEOUT_CYCLES, the parser returns to P_HDR and the partial frame is dropped silently.
- CMD_TIMEOUT_EN undefined: no counter. A partial frame waits indefinitely; only `rx_err` or a completed frame clears it.

## Test plan
- Reset, then rx A5 01 02 → `width`=2 the cycle after the third `rx_valid`; tx bytes 5A then 0x82 (sync=0, ovf=0, trace_en=0).
- rx A5 01 03 → NAK: tx 5A, 0x04; `width` stays 4.
- `trace_en`=1, `data_avail` held with bytes 11, 22, and A5 03 00 arriving during byte 11 → tx order 11, 5A, status, 22; `data_req` pulses exactly twice.
- With `trace_en`=0 and `data_avail`=1 → `tx_transmit` stays 0 and `data_req` stays 0 for 1000 cycles.
- rx A5 01, then `rx_err`, then 04 → no reply; `width` unchanged. Repeat with A5 01, idle TIMEOUT_CYCLES, then 01: CMD_TIMEOUT_EN → no change; undefined → `width`=1 and ACK.
- Assert `rst` low while `tx_transmit`=1 → all outputs at reset values immediately; the next command works normally.
